// File: rtl/rvsteel_mem_responder_if.sv
// Request/response bus between rvsteel_core (master) and a memory target (slave).
interface rvsteel_mem_responder_if;
    logic [31:0] rw_address;
    logic        read_request;
    logic [31:0] read_data;
    logic        read_response;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_request;
    logic        write_response;
    logic        access_fault;

    modport master (
        output rw_address,
        output read_request,
        output write_data,
        output write_strobe,
        output write_request,
        input  read_data,
        input  read_response,
        input  write_response,
        input  access_fault
    );

    modport slave (
        input  rw_address,
        input  read_request,
        input  write_data,
        input  write_strobe,
        input  write_request,
        output read_data,
        output read_response,
        output write_response,
        output access_fault
    );
endinterface

// File: rtl/rvsteel_mem_responder.sv
// Word-organised RAM target for the rvsteel_core bus: byte-strobed writes,
// programmable wait states and out-of-range fault reporting.
module rvsteel_mem_responder #(
    parameter int unsigned MEMORY_SIZE  = 4096,
    parameter string       MEMORY_FILE  = "",
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES  = 0
) (
    input logic                     clk,
    input logic                     reset,
    rvsteel_mem_responder_if.slave  bus
);

    localparam int unsigned RAM_DEPTH = MEMORY_SIZE / 4;
    localparam int unsigned IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic             write;
        logic             fault;
        logic [IDX_W-1:0] index;
        logic [31:0]      data;
        logic [3:0]       strobe;
    } txn_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    txn_t             txn_q;
    txn_t             txn_in_c;
    txn_t             txn_c;
    logic [31:0]      offset_c;
    logic             accept_c;
    logic             enter_resp_c;

    logic [31:0] ram [RAM_DEPTH];

    // Decode the incoming request; a write wins over a simultaneous read.
    always_comb begin
        offset_c        = bus.rw_address - BASE_ADDRESS;
        txn_in_c.write  = bus.write_request;
        txn_in_c.fault  = (offset_c >= 32'(MEMORY_SIZE));
        txn_in_c.index  = IDX_W'(offset_c >> 2);
        txn_in_c.data   = bus.write_data;
        txn_in_c.strobe = bus.write_strobe;
    end

    // With zero wait states the commit edge is the acceptance edge, so use live inputs.
    assign txn_c = (state_q == ST_IDLE) ? txn_in_c : txn_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        accept_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.write_request || bus.read_request) begin
                    accept_c = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        count_d = CNT_W'(WAIT_CYCLES - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (count_q == '0) state_d = ST_RESP;
                else               count_d = count_q - CNT_W'(1);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_resp_c = (state_d == ST_RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            count_q            <= '0;
            txn_q              <= '0;
            bus.read_data      <= '0;
            bus.read_response  <= 1'b0;
            bus.write_response <= 1'b0;
            bus.access_fault   <= 1'b0;
        end else begin
            state_q            <= state_d;
            count_q            <= count_d;
            if (accept_c) txn_q <= txn_in_c;
            bus.read_response  <= enter_resp_c && !txn_c.write;
            bus.write_response <= enter_resp_c && txn_c.write;
            bus.access_fault   <= enter_resp_c && txn_c.fault;
            if (enter_resp_c && !txn_c.write)
                bus.read_data <= txn_c.fault ? '0 : ram[txn_c.index];
        end
    end

    // Write commit; gated by reset so an aborted transaction never lands.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp_c && txn_c.write && !txn_c.fault) begin
            for (int i = 0; i < 4; i++) begin
                if (txn_c.strobe[i]) ram[txn_c.index][8*i +: 8] <= txn_c.data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_rvsteel_mem_responder.sv
// Scoreboard bench for rvsteel_mem_responder: zero-wait and three-wait instances.
module tb_rvsteel_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst3;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rvsteel_mem_responder_if b0();
    rvsteel_mem_responder_if b3();

    rvsteel_mem_responder #(
        .MEMORY_SIZE(4096), .MEMORY_FILE(""), .BASE_ADDRESS(32'h0000_0000), .WAIT_CYCLES(0)
    ) dut0 (.clk(clk), .reset(rst0), .bus(b0));

    rvsteel_mem_responder #(
        .MEMORY_SIZE(1024), .MEMORY_FILE(""), .BASE_ADDRESS(32'h8000_0000), .WAIT_CYCLES(3)
    ) dut3 (.clk(clk), .reset(rst3), .bus(b3));

    typedef struct {
        bit          wr;
        bit          fault;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    int checks   = 0;
    int failures = 0;
    int done0 = 0, done3 = 0, sent0 = 0, sent3 = 0;
    logic [31:0] last0 = '0;
    logic [31:0] last3 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_resp(input string tag, input logic rr, input logic wr, input logic af,
                                input logic [31:0] rd, input exp_t x);
        check({tag, "_read_response"},  32'(rr), 32'(!x.wr));
        check({tag, "_write_response"}, 32'(wr), 32'(x.wr));
        check({tag, "_access_fault"},   32'(af), 32'(x.fault));
        check({tag, "_read_data"},      rd, x.data);
        check({tag, "_latency_cycle"},  cyc, x.cyc);
    endtask

    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge clk);
            if (b0.read_response || b0.write_response || b0.access_fault) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dut0_unexpected_response: got rr=%0b wr=%0b af=%0b required none",
                             b0.read_response, b0.write_response, b0.access_fault);
                end else begin
                    x = q0.pop_front();
                    compare_resp("dut0", b0.read_response, b0.write_response, b0.access_fault, b0.read_data, x);
                end
                done0++;
            end
            if (b3.read_response || b3.write_response || b3.access_fault) begin
                if (q3.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dut3_unexpected_response: got rr=%0b wr=%0b af=%0b required none",
                             b3.read_response, b3.write_response, b3.access_fault);
                end else begin
                    x = q3.pop_front();
                    compare_resp("dut3", b3.read_response, b3.write_response, b3.access_fault, b3.read_data, x);
                end
                done3++;
            end
        end
    endtask

    task automatic drive(input int which, input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        if (which == 0) begin
            b0.write_request = wr; b0.read_request = rd;
            b0.rw_address = addr;  b0.write_data = data; b0.write_strobe = strb;
        end else begin
            b3.write_request = wr; b3.read_request = rd;
            b3.rw_address = addr;  b3.write_data = data; b3.write_strobe = strb;
        end
    endtask

    // Writes expect read_data to still hold the last read word.
    task automatic expect_resp(input int which, input bit wr, input bit fault,
                               input logic [31:0] rdata, input int unsigned lat);
        exp_t x;
        x.wr    = wr;
        x.fault = fault;
        x.cyc   = cyc + lat;
        if (which == 0) begin
            x.data = wr ? last0 : rdata;
            if (!wr) last0 = rdata;
            q0.push_back(x); sent0++;
        end else begin
            x.data = wr ? last3 : rdata;
            if (!wr) last3 = rdata;
            q3.push_back(x); sent3++;
        end
    endtask

    task automatic wait_done(input int which, input int target, input string name);
        bit ok;
        int got;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #1;
            got = (which == 0) ? done0 : done3;
            ok  = (got >= target);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got %0d responses required %0d", name, got, target);
        end
    endtask

    task automatic txn(input int which, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input bit fault, input logic [31:0] rexp, input string name);
        int unsigned lat;
        lat = (which == 0) ? 1 : 4;
        @(negedge clk);
        drive(which, wr, !wr, addr, data, strb);
        expect_resp(which, wr, fault, rexp, lat);
        wait_done(which, (which == 0) ? sent0 : sent3, name);
        drive(which, 1'b0, 1'b0, addr, data, strb);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            monitor();
        join_none
        rst0 = 1'b1; rst3 = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;
        @(negedge clk); #1;
        check("reset_dut0_read_data",      b0.read_data,            32'h0);
        check("reset_dut0_read_response",  32'(b0.read_response),   32'h0);
        check("reset_dut0_write_response", 32'(b0.write_response),  32'h0);
        check("reset_dut0_access_fault",   32'(b0.access_fault),    32'h0);
        check("reset_dut3_read_data",      b3.read_data,            32'h0);
        check("reset_dut3_read_response",  32'(b3.read_response),   32'h0);

        // Zero wait states: full write, partial strobe, empty strobe, faults.
        txn(0, 1, 32'h10,   32'h1234_5678, 4'hF, 0, '0,            "w_full");
        txn(0, 0, 32'h10,   '0,            4'h0, 0, 32'h1234_5678, "r_full");
        txn(0, 1, 32'h10,   32'hAABB_CCDD, 4'h5, 0, '0,            "w_strobe");
        txn(0, 0, 32'h10,   '0,            4'h0, 0, 32'h12BB_56DD, "r_strobe");
        txn(0, 1, 32'h10,   32'hFFFF_FFFF, 4'h0, 0, '0,            "w_nostrobe");
        txn(0, 0, 32'h13,   '0,            4'h0, 0, 32'h12BB_56DD, "r_nostrobe");
        txn(0, 1, 32'h0,    32'hCAFE_F00D, 4'hF, 0, '0,            "w_word0");
        txn(0, 0, 32'h1000, '0,            4'h0, 1, 32'h0,         "r_fault");
        txn(0, 1, 32'h1000, 32'h1111_1111, 4'hF, 1, '0,            "w_fault");
        txn(0, 0, 32'h0,    '0,            4'h0, 0, 32'hCAFE_F00D, "r_word0");

        // Simultaneous requests: write first, read accepted in the next IDLE cycle.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 32'h0F0F_1234, 4'hF);
        expect_resp(0, 1, 0, '0, 1);
        expect_resp(0, 0, 0, 32'h0F0F_1234, 3);
        wait_done(0, sent0 - 1, "sim_write");
        b0.write_request = 1'b0;
        wait_done(0, sent0, "sim_read");
        drive(0, 1'b0, 1'b0, '0, '0, '0);

        // Three wait states, non-zero base, range edges and address wrap.
        txn(1, 1, 32'h8000_0030, 32'h0BAD_F00D, 4'hF, 0, '0,            "w3_30");
        txn(1, 0, 32'h8000_0030, '0,            4'h0, 0, 32'h0BAD_F00D, "r3_30");
        txn(1, 0, 32'h8000_0400, '0,            4'h0, 1, 32'h0,         "r3_past_end");
        txn(1, 0, 32'h7FFF_FFFC, '0,            4'h0, 1, 32'h0,         "r3_below_base");
        txn(1, 1, 32'h8000_03FC, 32'h0102_0304, 4'hF, 0, '0,            "w3_last");
        txn(1, 0, 32'h8000_03FF, '0,            4'h0, 0, 32'h0102_0304, "r3_last");

        // Reset while a write waits: no response, RAM untouched.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h8000_0030, 32'hDEAD_BEEF, 4'hF);
        repeat (2) @(negedge clk);
        rst3 = 1'b1;
        #1;
        check("abort_read_data",      b3.read_data,           32'h0);
        check("abort_read_response",  32'(b3.read_response),  32'h0);
        check("abort_write_response", 32'(b3.write_response), 32'h0);
        check("abort_access_fault",   32'(b3.access_fault),   32'h0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        last3 = '0;
        repeat (6) @(negedge clk);
        txn(1, 0, 32'h8000_0030, '0, 4'h0, 0, 32'h0BAD_F00D, "r3_after_abort");

        repeat (8) @(negedge clk);
        check("dut0_pending", 32'(q0.size()), 32'h0);
        check("dut3_pending", 32'(q3.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
